// File: rtl/ppu_types_pkg.sv
// Shared PPU types: PPU mode encoding, VRAM owner tags and VRAM geometry.
package ppu_types_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;
    localparam int unsigned VRAM_DATA_W = 8;
    localparam logic [15:0] VRAM_BASE   = 16'h8000;

    // STAT[1:0] mode encoding
    typedef enum logic [1:0] {
        PPU_MODE_0 = 2'd0,  // HBlank
        PPU_MODE_1 = 2'd1,  // VBlank
        PPU_MODE_2 = 2'd2,  // OAM scan
        PPU_MODE_3 = 2'd3   // pixel transfer
    } ppu_mode_t;

    // Who issued (or was refused) the VRAM access of the previous cycle
    typedef enum logic [2:0] {
        OWN_NONE        = 3'd0,
        OWN_CPU         = 3'd1,
        OWN_CPU_BLOCKED = 3'd2,
        OWN_BG          = 3'd3,
        OWN_OBJ         = 3'd4
    } vram_owner_t;

endpackage

// File: rtl/ppu_util_pkg.sv
// Small PPU helper functions.
package ppu_util_pkg;

    import ppu_types_pkg::*;

    // True when a CPU-space address falls in the 0x8000-0x9FFF VRAM window
    function automatic logic in_vram(input logic [15:0] addr);
        return (addr & 16'hE000) == VRAM_BASE;
    endfunction

endpackage

// File: rtl/vram_grant_logic.sv
// Combinational VRAM grant decision.
// Inside the fetch window (lcd_en && mode 3): OBJ > BG > CPU. Outside it only
// the CPU can be granted and fetcher requests are ignored.
// Optional macro VRAM_ARB_CPU_BLOCK_EN: a CPU access reaching the front of the
// queue inside the fetch window is refused (OWN_CPU_BLOCKED) instead of served.
// Ports:
//   enable      - low suppresses every grant (reset)
//   lcd_en/mode - PPU state deciding the fetch window
//   cpu_req     - CPU request, cpu_busy masks a request already issued
//   bg_req/obj_req - fetcher requests
//   grant_c     - owner tag for this cycle's access
//   bg_stall_c  - BG request lost to OBJ this cycle
module vram_grant_logic
    import ppu_types_pkg::*;
(
    input  logic        enable,
    input  logic        lcd_en,
    input  ppu_mode_t   mode,
    input  logic        cpu_req,
    input  logic        cpu_busy,
    input  logic        bg_req,
    input  logic        obj_req,
    output vram_owner_t grant_c,
    output logic        bg_stall_c
);

    logic fetch_win;
    logic cpu_pending;

    always_comb begin
        grant_c     = OWN_NONE;
        bg_stall_c  = 1'b0;
        fetch_win   = lcd_en && (mode == PPU_MODE_3);
        cpu_pending = cpu_req && !cpu_busy;

        if (enable) begin
            if (fetch_win) begin
                bg_stall_c = bg_req && obj_req;
                if (obj_req) begin
                    grant_c = OWN_OBJ;
                end else if (bg_req) begin
                    grant_c = OWN_BG;
                end else if (cpu_pending) begin
`ifdef VRAM_ARB_CPU_BLOCK_EN
                    grant_c = OWN_CPU_BLOCKED;
`else
                    grant_c = OWN_CPU;
`endif
                end
            end else if (cpu_pending) begin
                grant_c = OWN_CPU;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter shared by the CPU bus, BG/window fetcher and OBJ
// fetcher. One access per cycle, read data returns one cycle later to the
// requester recorded in owner_q.
// Optional macro VRAM_ARB_CPU_BLOCK_EN: CPU accesses during mode 3 (LCD on) are
// refused (read 0xFF, write dropped). Undefined: the CPU is simply lowest
// priority during mode 3 and waits for a free cycle.
// Ports:
//   clk, reset_n                  - dot clock, async active-low reset
//   lcd_en, mode                  - LCDC[7], current PPU mode
//   cpu_req/we/addr/wdata         - CPU access, held until cpu_ack
//   cpu_ack, cpu_rdata            - completion pulse and read data
//   bg_req/addr, bg_rdata/valid   - BG fetch request and returned data
//   bg_stall                      - BG lost arbitration this cycle
//   obj_req/addr, obj_rdata/valid - OBJ fetch request and returned data
//   vram_en/we/addr/wdata/rdata   - synchronous VRAM macro port
module vram_arbiter
    import ppu_types_pkg::*;
    import ppu_util_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              lcd_en,
    input  ppu_mode_t         mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              bg_req,
    input  logic [15:0]       bg_addr,
    output logic [DATA_W-1:0] bg_rdata,
    output logic              bg_valid,
    output logic              bg_stall,
    input  logic              obj_req,
    input  logic [15:0]       obj_addr,
    output logic [DATA_W-1:0] obj_rdata,
    output logic              obj_valid,
    output logic              vram_en,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam logic [DATA_W-1:0] OPEN_BUS = {DATA_W{1'b1}};

    vram_owner_t grant_c;
    vram_owner_t owner_q;
    logic        cpu_busy_q;
    logic        oob_q;        // previous access was outside VRAM space
    logic [15:0] sel_addr_c;
    logic        sel_in_vram_c;
    logic        cpu_grant_c;

    // Grants are held off while reset is asserted so the macro stays idle
    vram_grant_logic u_grant (
        .enable     (reset_n),
        .lcd_en     (lcd_en),
        .mode       (mode),
        .cpu_req    (cpu_req),
        .cpu_busy   (cpu_busy_q),
        .bg_req     (bg_req),
        .obj_req    (obj_req),
        .grant_c    (grant_c),
        .bg_stall_c (bg_stall)
    );

    // Address select and macro drive for this cycle's grant
    always_comb begin
        sel_addr_c = cpu_addr;
        case (grant_c)
            OWN_BG:  sel_addr_c = bg_addr;
            OWN_OBJ: sel_addr_c = obj_addr;
            default: sel_addr_c = cpu_addr;
        endcase
        sel_in_vram_c = in_vram(sel_addr_c);
        cpu_grant_c   = (grant_c == OWN_CPU) || (grant_c == OWN_CPU_BLOCKED);
        vram_en       = 1'b0;
        vram_we       = 1'b0;
        if ((grant_c inside {OWN_CPU, OWN_BG, OWN_OBJ}) && sel_in_vram_c) begin
            vram_en = 1'b1;
            vram_we = (grant_c == OWN_CPU) && cpu_we;
        end
    end

    assign vram_addr  = sel_addr_c[ADDR_W-1:0];
    assign vram_wdata = cpu_wdata;

    // Owner tracking and completion pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_NONE;
            oob_q      <= 1'b0;
            cpu_busy_q <= 1'b0;
            cpu_ack    <= 1'b0;
            bg_valid   <= 1'b0;
            obj_valid  <= 1'b0;
        end else begin
            owner_q   <= grant_c;
            oob_q     <= !sel_in_vram_c;
            cpu_ack   <= cpu_grant_c;
            bg_valid  <= (grant_c == OWN_BG);
            obj_valid <= (grant_c == OWN_OBJ);
            // A held cpu_req must not be issued twice before its ack
            if (cpu_grant_c) begin
                cpu_busy_q <= 1'b1;
            end else if (cpu_ack) begin
                cpu_busy_q <= 1'b0;
            end
        end
    end

    // Return path: only the recorded owner sees macro data, everyone else 0xFF
    always_comb begin
        cpu_rdata = OPEN_BUS;
        bg_rdata  = OPEN_BUS;
        obj_rdata = OPEN_BUS;
        if (!oob_q) begin
            case (owner_q)
                OWN_CPU: cpu_rdata = vram_rdata;
                OWN_BG:  bg_rdata  = vram_rdata;
                OWN_OBJ: obj_rdata = vram_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM macro.
module tb_vram_arbiter;

    import ppu_types_pkg::*;

`ifdef VRAM_ARB_CPU_BLOCK_EN
    localparam logic BLK = 1'b1;
`else
    localparam logic BLK = 1'b0;
`endif
    // 0x9800 holds 0x77 from preload; a non-blocked mode-3 write changes it to 0xEE
    localparam logic [7:0] V9800 = BLK ? 8'h77 : 8'hEE;

    logic        clk;
    logic        reset_n;
    logic        lcd_en;
    ppu_mode_t   mode;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        bg_req;
    logic [15:0] bg_addr;
    logic [7:0]  bg_rdata;
    logic        bg_valid, bg_stall;
    logic        obj_req;
    logic [15:0] obj_addr;
    logic [7:0]  obj_rdata;
    logic        obj_valid;
    logic        vram_en, vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lcd_en     (lcd_en),
        .mode       (mode),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .bg_req     (bg_req),
        .bg_addr    (bg_addr),
        .bg_rdata   (bg_rdata),
        .bg_valid   (bg_valid),
        .bg_stall   (bg_stall),
        .obj_req    (obj_req),
        .obj_addr   (obj_addr),
        .obj_rdata  (obj_rdata),
        .obj_valid  (obj_valid),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous VRAM macro, preloaded with known bytes while in reset
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[13'h0000] <= 8'h3C;
            mem[13'h1800] <= 8'h77;
            mem[13'h0010] <= 8'h11;
        end else if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata     <= mem[vram_addr];
        end
    end

    typedef struct {
        logic        lcd;
        ppu_mode_t   md;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        breq;
        logic [15:0] baddr;
        logic        oreq;
        logic [15:0] oaddr;
        logic        e_en;
        logic        e_we;
        logic [12:0] e_addr;
        logic        e_stall;
        logic        e_ack;
        logic        e_bgv;
        logic        e_objv;
        logic        chk_crd;
        logic [7:0]  e_crd;
        logic [7:0]  e_brd;
        logic [7:0]  e_ord;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        bg_req   = 1'b0;
        obj_req  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] c, input logic [7:0] b, input logic [7:0] o);
        chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(c));
        chk({tag, " bg_rdata"},  32'(bg_rdata),  32'(b));
        chk({tag, " obj_rdata"}, 32'(obj_rdata), 32'(o));
    endtask

    initial begin
        // lcd, mode, cpu req/we/addr/wdata, bg req/addr, obj req/addr,
        // exp en/we/addr/stall, exp ack/bgv/objv, check cpu_rdata, exp rdata cpu/bg/obj
        vec[0]  = '{1'b1, PPU_MODE_0, 1'b1, 1'b1, 16'h8010, 8'h5A, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    1'b1, 1'b1, 13'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vec[1]  = '{1'b1, PPU_MODE_0, 1'b1, 1'b0, 16'h8010, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    1'b1, 1'b0, 13'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'hFF, 8'hFF};
        vec[2]  = '{1'b1, PPU_MODE_3, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    !BLK, 1'b0, 13'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (BLK ? 8'hFF : 8'h77), 8'hFF, 8'hFF};
        vec[3]  = '{1'b1, PPU_MODE_3, 1'b1, 1'b1, 16'h9800, 8'hEE, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    !BLK, !BLK, 13'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vec[4]  = '{1'b1, PPU_MODE_0, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    1'b1, 1'b0, 13'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, V9800, 8'hFF, 8'hFF};
        vec[5]  = '{1'b1, PPU_MODE_3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800, 1'b1, 16'h8000,
                    1'b1, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h3C};
        vec[6]  = '{1'b1, PPU_MODE_3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800, 1'b0, 16'h0000,
                    1'b1, 1'b0, 13'h1800, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, V9800, 8'hFF};
        vec[7]  = '{1'b0, PPU_MODE_3, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 16'h9800, 1'b0, 16'h0000,
                    1'b1, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hFF, 8'hFF};
        vec[8]  = '{1'b1, PPU_MODE_0, 1'b1, 1'b0, 16'h7FFF, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vec[9]  = '{1'b1, PPU_MODE_3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hA000, 1'b0, 16'h0000,
                    1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vec[10] = '{1'b1, PPU_MODE_1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800, 1'b0, 16'h0000,
                    1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vec[11] = '{1'b1, PPU_MODE_2, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800, 1'b1, 16'h8000,
                    1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vec[12] = '{1'b1, PPU_MODE_0, 1'b1, 1'b1, 16'hC000, 8'hAA, 1'b0, 16'h0000, 1'b0, 16'h0000,
                    1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};

        // Reset with a CPU write request present: nothing may reach the macro
        reset_n   = 1'b0;
        lcd_en    = 1'b1;
        mode      = PPU_MODE_0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h8000;
        cpu_wdata = 8'h99;
        bg_req    = 1'b1;
        bg_addr   = 16'h8000;
        obj_req   = 1'b0;
        obj_addr  = 16'h8000;
        tick();
        tick();
        @(negedge clk);
        chk("rst vram_en", 32'(vram_en), 32'd0);
        chk("rst vram_we", 32'(vram_we), 32'd0);
        chk("rst cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst bg_valid", 32'(bg_valid), 32'd0);
        chk("rst obj_valid", 32'(obj_valid), 32'd0);
        chk_rd("rst", 8'hFF, 8'hFF, 8'hFF);
        tick();
        idle();
        reset_n = 1'b1;
        tick();

        // Table: one access, one idle cycle for the return
        for (int i = 0; i < NV; i++) begin
            lcd_en    = vec[i].lcd;
            mode      = vec[i].md;
            cpu_req   = vec[i].creq;
            cpu_we    = vec[i].cwe;
            cpu_addr  = vec[i].caddr;
            cpu_wdata = vec[i].cwd;
            bg_req    = vec[i].breq;
            bg_addr   = vec[i].baddr;
            obj_req   = vec[i].oreq;
            obj_addr  = vec[i].oaddr;
            @(negedge clk);
            chk($sformatf("v%0d vram_en", i), 32'(vram_en), 32'(vec[i].e_en));
            chk($sformatf("v%0d vram_we", i), 32'(vram_we), 32'(vec[i].e_we));
            if (vec[i].e_en)
                chk($sformatf("v%0d vram_addr", i), 32'(vram_addr), 32'(vec[i].e_addr));
            chk($sformatf("v%0d bg_stall", i), 32'(bg_stall), 32'(vec[i].e_stall));
            tick();
            idle();
            @(negedge clk);
            chk($sformatf("v%0d cpu_ack", i), 32'(cpu_ack), 32'(vec[i].e_ack));
            chk($sformatf("v%0d bg_valid", i), 32'(bg_valid), 32'(vec[i].e_bgv));
            chk($sformatf("v%0d obj_valid", i), 32'(obj_valid), 32'(vec[i].e_objv));
            if (vec[i].chk_crd)
                chk($sformatf("v%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vec[i].e_crd));
            chk($sformatf("v%0d bg_rdata", i), 32'(bg_rdata), 32'(vec[i].e_brd));
            chk($sformatf("v%0d obj_rdata", i), 32'(obj_rdata), 32'(vec[i].e_ord));
            tick();
        end

        // OBJ wins, BG re-requests the very next cycle
        lcd_en = 1'b1; mode = PPU_MODE_3;
        obj_req = 1'b1; obj_addr = 16'h8000;
        bg_req  = 1'b1; bg_addr  = 16'h9800;
        @(negedge clk);
        chk("b2b obj addr", 32'(vram_addr), 32'h0000);
        chk("b2b stall", 32'(bg_stall), 32'd1);
        tick();
        obj_req = 1'b0;
        @(negedge clk);
        chk("b2b obj_valid", 32'(obj_valid), 32'd1);
        chk("b2b obj_rdata", 32'(obj_rdata), 32'h3C);
        chk("b2b bg en", 32'(vram_en), 32'd1);
        chk("b2b bg addr", 32'(vram_addr), 32'h1800);
        chk("b2b stall off", 32'(bg_stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("b2b bg_valid", 32'(bg_valid), 32'd1);
        chk("b2b bg_rdata", 32'(bg_rdata), 32'(V9800));
        chk("b2b obj_valid off", 32'(obj_valid), 32'd0);
        tick();

        // CPU read issued in mode 2, mode 3 begins while the request is still held
        mode = PPU_MODE_2;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        @(negedge clk);
        chk("mchg en", 32'(vram_en), 32'd1);
        tick();
        mode = PPU_MODE_3;
        @(negedge clk);
        chk("mchg ack", 32'(cpu_ack), 32'd1);
        chk("mchg rdata", 32'(cpu_rdata), 32'h3C);
        chk("mchg no reissue", 32'(vram_en), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("mchg ack off", 32'(cpu_ack), 32'd0);
        tick();

        // CPU and BG together in mode 3: BG first, CPU served or refused after
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        bg_req  = 1'b1; bg_addr = 16'h9800;
        @(negedge clk);
        chk("cpubg bg addr", 32'(vram_addr), 32'h1800);
        tick();
        bg_req = 1'b0;
        @(negedge clk);
        chk("cpubg bg_valid", 32'(bg_valid), 32'd1);
        chk("cpubg bg_rdata", 32'(bg_rdata), 32'(V9800));
        chk("cpubg no early ack", 32'(cpu_ack), 32'd0);
        chk("cpubg cpu en", 32'(vram_en), 32'(!BLK));
        tick();
        @(negedge clk);
        chk("cpubg ack", 32'(cpu_ack), 32'd1);
        chk("cpubg rdata", 32'(cpu_rdata), BLK ? 32'hFF : 32'h3C);
        tick();
        idle();
        @(negedge clk);
        chk("cpubg ack once", 32'(cpu_ack), 32'd0);
        tick();

        // Reset lands while a BG read is in flight
        bg_req = 1'b1; bg_addr = 16'h8000;
        @(negedge clk);
        chk("rstmid en", 32'(vram_en), 32'd1);
        tick();
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstmid bg_valid", 32'(bg_valid), 32'd0);
        chk("rstmid vram_en", 32'(vram_en), 32'd0);
        chk("rstmid cpu_ack", 32'(cpu_ack), 32'd0);
        chk_rd("rstmid", 8'hFF, 8'hFF, 8'hFF);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid post bg_valid", 32'(bg_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("rstmid post2 bg_valid", 32'(bg_valid), 32'd0);
        chk("rstmid post2 bg_rdata", 32'(bg_rdata), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access arbiter for the PPU. Shares one synchronous 8 KiB VRAM macro between the CPU bus, the background/window tile fetcher and the sprite (OBJ) fetcher. Enforces PPU-mode access rules: fetchers own VRAM during mode 3, the CPU owns it otherwise. Issues one access per cycle and routes the one-cycle-latency read data back to the requester that was granted.

## Interface
- ADDR_W, 13, VRAM word address width (0x8000–0x9FFF → 0x0000–0x1FFF)
- DATA_W, 8, data width
- clk  in  1  PPU dot clock
- reset_n  in  1  asynchronous, active-low reset
- lcd_en  in  1  LCDC[7]
- mode  in  2  current PPU mode (ppu_mode_t)
- cpu_req / cpu_we  in  1 / 1  CPU access request (held until cpu_ack) / write enable
- cpu_addr / cpu_wdata  in  16 / DATA_W  CPU address / write data
- cpu_ack  out  1  one-cycle pulse, access complete
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack
- bg_req / bg_addr  in  1 / 16  BG fetcher read request (single cycle) / address
- bg_rdata / bg_valid  out  DATA_W / 1  BG read data / valid pulse
- bg_stall  out  1  BG request not granted this cycle; fetcher must hold its phase
- obj_req / obj_addr  in  1 / 16  sprite fetcher read request / address
- obj_rdata / obj_valid  out  DATA_W / 1  sprite read data / valid pulse
- vram_en / vram_we  out  1 / 1  macro enable / write enable
- vram_addr / vram_wdata  out  ADDR_W / DATA_W  macro address / write data
- vram_rdata  in  DATA_W  macro read data, one cycle after vram_en

## Operation
- Clock is clk; reset is asynchronous and active-low (reset_n).
- Owner register owner_q ∈ {OWN_NONE, OWN_CPU, OWN_CPU_BLOCKED, OWN_BG, OWN_OBJ}; records who issued the previous-cycle access.
- Fetch window = lcd_en && mode == PPU_MODE_3.
- Grant each cycle, inside fetch window: obj_req > bg_req > CPU; CPU is blocked (see Configuration). Outside: CPU only; bg_req/obj_req ignored (no valid, bg_stall = 0).
- Address: vram_addr = addr[12:0]. Request with addr[15:13] != 3'b100: no vram_en; reads return 0xFF; writes dropped; ack/valid still produced.
- Blocked CPU access: no vram_en; owner_q ← OWN_CPU_BLOCKED; cpu_rdata 0xFF; write dropped.
- cpu_busy_q flag set on CPU grant or block, cleared with cpu_ack; CPU request is not re-sampled while cpu_busy_q (no double issue of a held request).
- bg_stall = bg_req && obj_req inside fetch window (combinational).
- Read mux: rdata of owner_q's requester = vram_rdata; all non-owning rdata outputs = 0xFF.

## Timing
- Cycle N: request sampled, vram_* driven combinationally from grant, owner_q registered at N's edge.
- Cycle N+1: cpu_ack / bg_valid / obj_valid high one cycle (registered), rdata valid. Latency 1; throughput 1 access/cycle.
- Write: vram_we in cycle N; cpu_ack in N+1.
- Reset: owner_q = OWN_NONE, cpu_busy_q = 0, cpu_ack = bg_valid = obj_valid = 0, vram_en = vram_we = 0, all rdata = 0xFF.
- reset_n asserted mid-access: in-flight read discarded, no valid/ack pulse after release.
- Mode change between N and N+1: the access issued in N completes normally (owner_q governs return).
- Entering mode 3 in the same cycle a CPU request arrives: mode at cycle N decides → blocked.
- lcd_en = 0: CPU unrestricted regardless of mode.
- Simultaneous obj_req and bg_req: OBJ granted, bg_stall = 1, BG re-requests next cycle.

## Configuration
- VRAM_ARB_CPU_BLOCK_EN defined: CPU accesses inside the fetch window are blocked as above (hardware-accurate).
- Undefined: CPU is lowest priority inside the fetch window and is granted in any cycle with neither fetcher requesting; held cpu_req waits (no 0xFF). For debug/bring-up only.

## Structure
- ppu_types_pkg: vram_owner_t enum, VRAM_ADDR_W, VRAM_BASE (16'h8000); reuse existing ppu_mode_t and PPU_MODE_3.
- ppu_util_pkg: function in_vram(addr) (addr[15:13] == 3'b100).
- One sub-module natural: vram_grant_logic (combinational priority/blocking decision); owner register, pulses and read mux stay in vram_arbiter.

## Test plan
- Mode 0, CPU write 0x8010 ← 0x5A, then read 0x8010 → cpu_ack each one cycle later, cpu_rdata = 0x5A.
- Mode 3, lcd_en = 1, CPU read 0x9800 → no vram_en, cpu_ack next cycle, cpu_rdata = 0xFF; CPU write dropped (later mode-0 read returns old value).
- Mode 3, bg_req and obj_req together at 0x9800/0x8000 → OBJ served, bg_stall = 1; BG re-request next cycle → bg_valid with macro data at 0x9800.
- lcd_en = 0, mode = 3, CPU read 0x8000 (preloaded 0x3C) → cpu_rdata = 0x3C; bg_req ignored, bg_valid stays 0.
- CPU read issued in mode 2 last cycle, mode switches to 3 → read completes with correct data, not 0xFF.
- reset_n low the cycle after a BG request → no bg_valid; all outputs at reset values.
